// File: rtl/dtree_feature_loader.sv
// Byte-stream front end for the combinational decision-tree core: assembles N_FEAT feature
// beats onto a parallel bus, holds it for SETTLE cycles, then returns the sampled class.
module dtree_feature_loader #(
  parameter int N_FEAT = 5,
  parameter int FEAT_W = 8,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FEAT_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [N_FEAT*FEAT_W-1:0] feat_bus,
  input  logic [OUT_W-1:0]         tree_out,
  output logic [OUT_W-1:0]         res_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     frame_err,
  output logic [CNT_W-1:0]         sample_cnt
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SETTLE,
    S_RESULT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [SET_W-1:0] settle_cnt;
  logic             accept;
  logic             at_last_slot;
  logic             settle_done;

  // in_ready depends only on state, so upstream never sees a path from in_valid.
  assign in_ready     = (state == S_LOAD);
  assign accept       = in_valid & in_ready;
  assign at_last_slot = (idx == LAST_IDX);
  assign settle_done  = (settle_cnt == LAST_SET);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_next = state;
    unique case (state)
      S_LOAD: begin
        if (accept && at_last_slot) begin
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_done) begin
          state_next = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          state_next = S_LOAD;
        end
      end
      default: state_next = S_LOAD;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      settle_cnt <= '0;
      feat_bus   <= '0;
      res_data   <= '0;
      res_valid  <= 1'b0;
      frame_err  <= 1'b0;
      sample_cnt <= '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          settle_cnt <= '0;
          if (accept) begin
            feat_bus[idx*FEAT_W +: FEAT_W] <= in_data;
            if (at_last_slot) begin
              // Missing in_last still completes the sample; the stream resyncs next beat.
              idx <= '0;
              if (!in_last) begin
                frame_err <= 1'b1;
              end
            end else if (in_last) begin
              // Early in_last abandons the partial sample; written slots keep their data.
              idx       <= '0;
              frame_err <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_SETTLE: begin
          if (settle_done) begin
            settle_cnt <= '0;
            res_data   <= tree_out;
            res_valid  <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            sample_cnt <= sample_cnt + CNT_W'(1);
          end
        end
        default: begin
          idx        <= '0;
          settle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Self-checking bench for dtree_feature_loader: table-driven samples with a result
// scoreboard, plus hand-written sequences for framing errors, backpressure and reset.
module tb_dtree_feature_loader;

  localparam int LAT = 4;

  typedef struct packed {
    logic [39:0] feat;
    logic        res;
  } exp_t;

  typedef struct {
    logic [4:0][7:0] beats;
    int              gap;
    logic [39:0]     exp_feat;
    logic            exp_res;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [39:0] feat_bus;
  logic        tree_out;
  logic        res_data;
  logic        res_valid;
  logic        res_ready;
  logic        frame_err;
  logic [15:0] sample_cnt;

  // Narrow-counter twin sharing the same stimulus, used to exercise counter wrap.
  logic        in_ready_w;
  logic [39:0] feat_bus_w;
  logic        tree_out_w;
  logic        res_data_w;
  logic        res_valid_w;
  logic        frame_err_w;
  logic [1:0]  sample_cnt_w;

  exp_t        sb[$];
  vec_t        vecs[5];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_results = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  // Stand-in classifier: class is bit 0 of X0.
  assign tree_out   = feat_bus[0];
  assign tree_out_w = feat_bus_w[0];

  dtree_feature_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .feat_bus(feat_bus), .tree_out(tree_out), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .frame_err(frame_err),
    .sample_cnt(sample_cnt)
  );

  dtree_feature_loader #(.CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_w), .feat_bus(feat_bus_w), .tree_out(tree_out_w),
    .res_data(res_data_w), .res_valid(res_valid_w), .res_ready(res_ready),
    .frame_err(frame_err_w), .sample_cnt(sample_cnt_w)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got res_data 0x%0h with no sample pending", res_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", res_data, e.res);
        check("feat_bus_at_result", feat_bus, e.feat);
      end
      exp_cnt++;
      n_results++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    exp_cnt = '0;
    sync();
    sync();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_feat_bus"}, feat_bus, 40'h0);
    check({tag, "_res_valid"}, res_valid, 1'b0);
    check({tag, "_res_data"}, res_data, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_sample_cnt"}, sample_cnt, 16'h0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_accept_timeout: in_ready low for %0d cycles", n);
    end
    sync();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_sample(input logic [4:0][7:0] beats, input int gap,
                             input int last_at, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      send_beat(beats[i], (i == last_at));
      if (i < nbeats - 1) repeat (gap) sync();
    end
  endtask

  // Counts negedges from the last-beat edge until res_valid; -1 on timeout.
  task automatic wait_result(output int lat);
    int ready_seen;
    ready_seen = 0;
    lat = 0;
    @(negedge clk);
    while (!res_valid && lat < 100) begin
      if (in_ready) ready_seen++;
      @(negedge clk);
      lat++;
    end
    if (!res_valid) lat = -1;
    check("in_ready_low_while_busy", ready_seen, 0);
    sync();
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.feat = v.exp_feat;
    e.res  = v.exp_res;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    push_exp(v);
    send_sample(v.beats, v.gap, 4, 5);
    wait_result(lat);
    check("latency", lat, LAT);
    check("sample_cnt", sample_cnt, exp_cnt);
  endtask

  task automatic set_vec(input int i, input logic [4:0][7:0] beats, input int gap,
                         input logic [39:0] feat, input logic res);
    vecs[i].beats    = beats;
    vecs[i].gap      = gap;
    vecs[i].exp_feat = feat;
    vecs[i].exp_res  = res;
  endtask

  initial begin
    int lat;
    int seen;
    int bad;
    int n0;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b0;

    set_vec(0, {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 0, 40'h32_28_1E_14_0A, 1'b0);
    set_vec(1, {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 0, 40'h05_04_03_02_01, 1'b1);
    set_vec(2, {8'h80, 8'h55, 8'hAA, 8'h00, 8'hFF}, 1, 40'h80_55_AA_00_FF, 1'b1);
    set_vec(3, {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 2, 40'h32_28_1E_14_0A, 1'b0);
    set_vec(4, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE}, 0, 40'hFF_FF_FF_FF_FE, 1'b0);

    // Reset state, then the table of samples with the result always accepted.
    do_reset();
    check_reset_state("reset");
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    check("cnt_after_table", sample_cnt, 16'd5);

    // Backpressure: result held for 20 cycles while beats are offered and refused.
    res_ready = 1'b0;
    push_exp(vecs[1]);
    send_sample(vecs[1].beats, 0, 4, 5);
    wait_result(lat);
    check("bp_latency", lat, LAT);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 1'b1 || in_ready !== 1'b0 ||
          feat_bus !== 40'h05_04_03_02_01) bad++;
    end
    check("bp_hold_bad_cycles", bad, 0);
    check("bp_cnt_held", sample_cnt, 16'd5);
    sync();
    in_valid  = 1'b0;
    res_ready = 1'b1;
    sync();
    check("bp_in_ready_after", in_ready, 1'b1);
    check("bp_res_valid_after", res_valid, 1'b0);
    check("bp_sample_cnt", sample_cnt, 16'd6);

    // Early in_last on the third beat: partial sample dropped, next sample works once.
    do_reset();
    send_sample({8'h00, 8'h00, 8'h33, 8'h22, 8'h11}, 0, 2, 3);
    check("early_frame_err", frame_err, 1'b1);
    check("early_partial_slots", feat_bus, 40'h00_00_33_22_11);
    check("early_in_ready", in_ready, 1'b1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("early_no_result", seen, 0);
    sync();
    n0 = n_results;
    run_vec(vecs[0]);
    repeat (5) sync();
    check("early_one_result", n_results - n0, 1);
    check("early_sb_empty", sb.size(), 0);
    check("early_frame_err_sticky", frame_err, 1'b1);

    // Missing in_last on the fifth beat: error flagged, result still produced.
    do_reset();
    push_exp(vecs[1]);
    send_sample(vecs[1].beats, 0, -1, 5);
    check("nolast_frame_err", frame_err, 1'b1);
    wait_result(lat);
    check("nolast_latency", lat, LAT);
    check("nolast_cnt", sample_cnt, 16'd1);
    run_vec(vecs[2]);
    check("nolast_resync_cnt", sample_cnt, 16'd2);

    // Reset during SETTLE: nothing survives and no result appears.
    do_reset();
    send_sample(vecs[0].beats, 0, 4, 5);
    repeat (2) sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    check_reset_state("rst_settle");
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("rst_settle_no_result", seen, 0);
    sync();

    // Reset in RESULT coinciding with res_ready: rst wins, counter stays 0.
    res_ready = 1'b0;
    push_exp(vecs[1]);
    send_sample(vecs[1].beats, 0, 4, 5);
    wait_result(lat);
    check("rst_result_latency", lat, LAT);
    check("rst_result_res_valid", res_valid, 1'b1);
    rst = 1'b1;
    res_ready = 1'b1;
    sb.delete();
    sync();
    rst = 1'b0;
    check_reset_state("rst_result");

    // Counter wrap on the 2-bit twin: 3 is all-ones, the fourth sample rolls to 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i]);
      if (i == 2) check("wrap_cnt_max", sample_cnt_w, 2'd3);
    end
    check("wrap_cnt_rolls", sample_cnt_w, 2'd0);
    check("wrap_wide_cnt", sample_cnt, 16'd4);

    repeat (3) sync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
